rst_seq_ctrl: RTL and testbench

// - Reset sequencer upstream of the per-domain reset synchronizers. It produces NUM_STAGES

---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/rst_seq_timer.sv | 28 ++
 rtl/rst_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, register map and defaults.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_POR    = 2'b00,
    ST_SWHOLD = 2'b01,
    ST_SEQ    = 2'b10,
    ST_RUN    = 2'b11
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_HOLD   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [7:0]  HOLD_DEF   = 8'd4;
  localparam int unsigned HOLD_SHIFT = 4;

  // A HOLD of zero behaves as one unit.
  function automatic logic [7:0] hold_eff(input logic [7:0] h);
    return (h == 8'd0) ? 8'd1 : h;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating down-counter shared by POR, SWHOLD and stage-gap timing.
module rst_seq_timer #(
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staggered reset-release sequencer with an Avalon-MM control slave.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned POR_HOLD   = 1024,
  parameter int unsigned STAGE_GAP  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            avs_address,
  input  logic                  avs_write,
  input  logic [7:0]            avs_writedata,
  input  logic                  avs_read,
  output logic [7:0]            avs_readdata,
  output logic [NUM_STAGES-1:0] o_rst_n,
  output logic                  o_busy
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_busy;
  logic [NUM_STAGES-1:0] r_rst_n;
  logic [NUM_STAGES-1:0] r_pending;
  logic [NUM_STAGES-1:0] r_mask;
  logic [7:0]            r_hold;
  logic                  r_sticky;
  logic [7:0]            r_readdata;

  logic                  w_tmr_load;
  logic [CNT_W-1:0]      w_tmr_val;
  logic                  w_tmr_en;
  logic                  w_tmr_done;
  logic                  w_ctrl_wr;
  logic                  w_trig;
  logic                  w_sw_start;
  logic                  w_release;
  logic                  w_found;
  logic [NUM_STAGES-1:0] w_low;
  logic [CNT_W-1:0]      w_gap_ld;
  logic [CNT_W-1:0]      w_hold_ld;
  logic [3:0]            w_rst_lo;
  logic [7:0]            w_mask_rd;
  logic [7:0]            w_status;

  rst_seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(POR_HOLD))
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  // A reload of N-1 makes the next event land N edges after the loading edge.
  assign w_gap_ld  = CNT_W'(STAGE_GAP - 1);
  assign w_hold_ld = (CNT_W'(hold_eff(r_hold)) << HOLD_SHIFT) - CNT_W'(1);

  assign w_ctrl_wr  = avs_write && (avs_address == ADDR_CTRL);
  assign w_trig     = w_ctrl_wr && avs_writedata[0];
  assign w_sw_start = (r_state == ST_RUN) && w_trig && (r_mask != '0);
  assign w_release  = (r_state == ST_SEQ) && w_tmr_done;

  // Next stage to release: lowest still-pending bit of the active set.
  always_comb begin
    w_low   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (!w_found && r_pending[k]) begin
        w_low[k] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = w_gap_ld;
    w_tmr_en    = (r_state != ST_RUN);
    case (r_state)
      ST_POR, ST_SWHOLD: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_SEQ;
          w_tmr_load  = 1'b1;
        end
      end
      ST_SEQ: begin
        if (w_tmr_done) begin
          if ((r_pending & ~w_low) == '0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_tmr_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_sw_start) begin
          w_state_nxt = ST_SWHOLD;
          w_tmr_load  = 1'b1;
          w_tmr_val   = w_hold_ld;
        end
      end
      default: w_state_nxt = ST_POR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_POR;
      r_busy    <= 1'b1;
      r_rst_n   <= '0;
      r_pending <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_RUN);
      if (w_release) begin
        r_rst_n   <= r_rst_n | w_low;
        r_pending <= r_pending & ~w_low;
      end else if (w_sw_start) begin
        r_rst_n   <= r_rst_n & ~r_mask;
        r_pending <= r_mask;
      end
    end
  end

  // Clear and trigger in one write: the trigger's set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask   <= '1;
      r_hold   <= HOLD_DEF;
      r_sticky <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_MASK)) r_mask <= avs_writedata[NUM_STAGES-1:0];
      if (avs_write && (avs_address == ADDR_HOLD)) r_hold <= avs_writedata;
      if (w_ctrl_wr && avs_writedata[1]) r_sticky <= 1'b0;
      if (w_trig && (r_state == ST_RUN)) r_sticky <= 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rst_lo
    if (g < NUM_STAGES) begin : g_on
      assign w_rst_lo[g] = r_rst_n[g];
    end else begin : g_off
      assign w_rst_lo[g] = 1'b0;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_mask_rd
    if (g < NUM_STAGES) begin : g_on
      assign w_mask_rd[g] = r_mask[g];
    end else begin : g_off
      assign w_mask_rd[g] = 1'b0;
    end
  end

  assign w_status = {w_rst_lo, r_state, r_sticky, r_busy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:   r_readdata <= '0;
        ADDR_MASK:   r_readdata <= w_mask_rd;
        ADDR_HOLD:   r_readdata <= r_hold;
        ADDR_STATUS: r_readdata <= w_status;
        default:     r_readdata <= '0;
      endcase
    end
  end

  assign avs_readdata = r_readdata;
  assign o_rst_n      = r_rst_n;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench: a timeline model of release times predicts outputs and register reads.
module tb_rst_seq_ctrl;

  localparam int NS  = 4;
  localparam int PH  = 32;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    avs_address;
  logic          avs_write;
  logic [7:0]    avs_writedata;
  logic          avs_read;
  logic [7:0]    avs_readdata;
  logic [NS-1:0] o_rst_n;
  logic          o_busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = -1;

  logic [4:0] q_out[$];
  logic [7:0] q_rd[$];

  // Model: each stage is low during [lowf, rel); the FSM phase follows from hold_end/seq_end.
  int         lowf[NS];
  int         rel[NS];
  int         hold_end;
  int         seq_end;
  bit         por_mode;
  logic [3:0] m_mask;
  logic [7:0] m_hold;
  bit         m_sticky;

  rst_seq_ctrl #(
    .NUM_STAGES (NS),
    .POR_HOLD   (PH),
    .STAGE_GAP  (GAP),
    .CNT_W      (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .o_rst_n       (o_rst_n),
    .o_busy        (o_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mstate(input int t);
    if (t < hold_end) return por_mode ? 0 : 1;
    if (t < seq_end) return 2;
    return 3;
  endfunction

  function automatic logic [3:0] exp_rst(input int t);
    logic [3:0] v;
    for (int k = 0; k < NS; k++) v[k] = !((t >= lowf[k]) && (t < rel[k]));
    return v;
  endfunction

  function automatic void model_reset(input int e0);
    por_mode = 1'b1;
    hold_end = e0 + PH;
    seq_end  = hold_end + GAP * NS;
    for (int k = 0; k < NS; k++) begin
      lowf[k] = -1000000;
      rel[k]  = hold_end + GAP * (k + 1);
    end
    m_mask   = 4'hF;
    m_hold   = 8'd4;
    m_sticky = 1'b0;
  endfunction

  function automatic void sw_trigger(input int e);
    int h;
    int j;
    h = (m_hold == 8'd0) ? 1 : int'(m_hold);
    j = 0;
    por_mode = 1'b0;
    hold_end = e + 16 * h;
    for (int k = 0; k < NS; k++) begin
      if (m_mask[k]) begin
        lowf[k] = e;
        rel[k]  = hold_end + GAP * (j + 1);
        j++;
      end
    end
    seq_end = hold_end + GAP * j;
  endfunction

  function automatic void model_edge(input bit w, input logic [1:0] a, input logic [7:0] d, input bit r);
    int         sb;
    logic [3:0] rb;
    logic [7:0] rd;
    sb = mstate(cyc - 1);
    rb = exp_rst(cyc - 1);
    if (r) begin
      case (a)
        2'd0:    rd = 8'h00;
        2'd1:    rd = {4'h0, m_mask};
        2'd2:    rd = m_hold;
        default: rd = {rb, 2'(sb), m_sticky, (sb != 3)};
      endcase
      q_rd.push_back(rd);
    end
    if (w) begin
      case (a)
        2'd0: begin
          if (d[1]) m_sticky = 1'b0;
          if (d[0] && (sb == 3)) begin
            m_sticky = 1'b1;
            if (m_mask != 4'h0) sw_trigger(cyc);
          end
        end
        2'd1:    m_mask = d[3:0];
        2'd2:    m_hold = d;
        default: ;
      endcase
    end
    q_out.push_back({(mstate(cyc) != 3), exp_rst(cyc)});
  endfunction

  // Called just after a rising edge; inputs are sampled at the next edge.
  task automatic tick(input bit w, input logic [1:0] a, input logic [7:0] d, input bit r);
    avs_write     = w;
    avs_address   = a;
    avs_writedata = d;
    avs_read      = r;
    @(posedge clk);
    cyc++;
    model_edge(w, a, d, r);
    #1;
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while ((mstate(cyc) != 3) && (n < 6000)) begin
      tick(1'b0, 2'd0, 8'h00, 1'b0);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_n", {4'h0, o_rst_n}, 8'h00);
    chk("async_busy", {7'h0, o_busy}, 8'h01);
    chk("async_rdata", avs_readdata, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset(cyc + 1);
  endtask

  initial begin : monitor
    bit rd_flag;
    logic [4:0] e;
    logic [7:0] r;
    forever begin
      @(posedge clk);
      rd_flag = avs_read && rst_n;
      @(negedge clk);
      if (q_out.size() != 0) begin
        e = q_out.pop_front();
        chk("o_rst_n", {4'h0, o_rst_n}, {4'h0, e[3:0]});
        chk("o_busy", {7'h0, o_busy}, {7'h0, e[4]});
      end
      if (rd_flag) begin
        if (q_rd.size() != 0) begin
          r = q_rd.pop_front();
          chk("readdata", avs_readdata, r);
        end else begin
          chk("rd_queue_empty", 8'h01, 8'h00);
        end
      end
    end
  end

  initial begin : stim
    avs_address   = 2'd0;
    avs_write     = 1'b0;
    avs_writedata = 8'h00;
    avs_read      = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("por_rst_n", {4'h0, o_rst_n}, 8'h00);
    chk("por_busy", {7'h0, o_busy}, 8'h01);
    chk("por_rdata", avs_readdata, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset(cyc + 1);

    // Power-on sequence, with register reads during POR.
    idle(3);
    tick(1'b0, 2'd1, 8'h00, 1'b1);
    tick(1'b0, 2'd2, 8'h00, 1'b1);
    tick(1'b0, 2'd3, 8'h00, 1'b1);
    wait_run();
    idle(2);

    // Masked software reset, retrigger mid-SEQ, sticky handling.
    tick(1'b1, 2'd1, 8'h0C, 1'b0);
    tick(1'b1, 2'd2, 8'h01, 1'b0);
    tick(1'b1, 2'd0, 8'h01, 1'b0);
    idle(18);
    tick(1'b1, 2'd0, 8'h01, 1'b0);
    tick(1'b0, 2'd3, 8'h00, 1'b1);
    wait_run();
    tick(1'b0, 2'd3, 8'h00, 1'b1);
    tick(1'b1, 2'd0, 8'h02, 1'b0);
    tick(1'b0, 2'd3, 8'h00, 1'b1);
    tick(1'b0, 2'd0, 8'h00, 1'b1);

    // Reset pulse in the middle of SEQ.
    tick(1'b1, 2'd0, 8'h01, 1'b0);
    idle(18);
    do_reset();
    tick(1'b0, 2'd1, 8'h00, 1'b1);
    tick(1'b0, 2'd2, 8'h00, 1'b1);
    wait_run();

    // HOLD=0 behaves as one unit; single stage.
    tick(1'b1, 2'd2, 8'h00, 1'b0);
    tick(1'b1, 2'd1, 8'h01, 1'b0);
    tick(1'b1, 2'd0, 8'h01, 1'b0);
    wait_run();

    // Empty mask: only sticky changes; trigger+clear together leaves sticky set.
    tick(1'b1, 2'd0, 8'h02, 1'b0);
    tick(1'b1, 2'd1, 8'h00, 1'b0);
    tick(1'b1, 2'd0, 8'h01, 1'b0);
    tick(1'b0, 2'd3, 8'h00, 1'b1);
    tick(1'b1, 2'd0, 8'h02, 1'b0);
    tick(1'b1, 2'd0, 8'h03, 1'b0);
    tick(1'b0, 2'd3, 8'h00, 1'b1);
    tick(1'b0, 2'd1, 8'h00, 1'b1);

    // Randomised traffic.
    for (int it = 0; it < 2500; it++) begin
      int sel;
      sel = $urandom_range(0, 15);
      case (sel)
        0:       tick(1'b1, 2'd1, 8'($urandom_range(0, 255)), 1'b0);
        1:       tick(1'b1, 2'd2, 8'($urandom_range(0, 2)), 1'b0);
        2, 3:    tick(1'b1, 2'd0, 8'($urandom_range(0, 3)), 1'b0);
        4:       tick(1'b1, 2'd3, 8'($urandom_range(0, 255)), 1'b0);
        5, 6:    tick(1'b0, 2'($urandom_range(0, 3)), 8'h00, 1'b1);
        default: tick(1'b0, 2'd0, 8'h00, 1'b0);
      endcase
      if (it == 1200) do_reset();
    end
    wait_run();
    tick(1'b0, 2'd3, 8'h00, 1'b1);
    idle(2);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
